// File: rtl/mult_table_scanner.sv
// mult_table_scanner: walks every (a,b) pair of the 8x8 times-table memory in
// row-major order, pairs each returned product with the operands that produced
// it, streams the result out on a valid/ready port and tallies mismatches
// against an arithmetic a*b for board-level memory self-test.
module mult_table_scanner #(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [2:0] mul_a,
  output logic [2:0] mul_b,
  output logic       mul_read,
  input  logic [5:0] mul_result,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_a,
  output logic [2:0] out_b,
  output logic [5:0] out_result,
  output logic       out_mismatch,
  output logic       busy,
  output logic       done,
  output logic [6:0] err_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [5:0] r_idx;
  logic [2:0] r_out_a;
  logic [2:0] r_out_b;
  logic       r_out_valid;
  logic [6:0] r_err_count;

  logic       w_read;
  logic       w_consume;
  logic       w_start_ok;
  logic       w_mismatch;
  logic       w_busy;
  logic       w_done;

  // Reference product; 7*7 = 49 fits in the 6-bit result width.
  function automatic logic [5:0] ref_product(input logic [2:0] a, input logic [2:0] b);
    logic [5:0] p;
    p = {3'b000, a} * {3'b000, b};
    return p;
  endfunction

  // A read is only issued when the output slot is free or being freed this
  // cycle, so the memory's held output always belongs to the presented beat.
  assign w_read    = (r_state == S_SCAN) && (!r_out_valid || out_ready);
  assign w_consume = r_out_valid && out_ready;
  assign w_mismatch = CHECK_EN && r_out_valid &&
                      (mul_result != ref_product(r_out_a, r_out_b));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and status decode.
  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        w_busy = 1'b1;
        if (w_read && (r_idx == 6'd63)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_consume) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (start) begin
          w_start_ok  = 1'b1;
          w_state_nxt = S_SCAN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Scan index, beat operand capture, beat valid and error tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= 6'd0;
      r_out_a     <= 3'd0;
      r_out_b     <= 3'd0;
      r_out_valid <= 1'b0;
      r_err_count <= 7'd0;
    end else begin
      if (w_start_ok) begin
        r_idx       <= 6'd0;
        r_err_count <= 7'd0;
      end else begin
        if (w_read) begin
          r_idx <= r_idx + 6'd1;
        end
        if (w_consume && w_mismatch) begin
          r_err_count <= r_err_count + 7'd1;
        end
      end
      if (w_read) begin
        r_out_a     <= r_idx[5:3];
        r_out_b     <= r_idx[2:0];
        r_out_valid <= 1'b1;
      end else if (w_consume) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign mul_a        = r_idx[5:3];
  assign mul_b        = r_idx[2:0];
  assign mul_read     = w_read;
  assign out_valid    = r_out_valid;
  assign out_a        = r_out_a;
  assign out_b        = r_out_b;
  assign out_result   = mul_result;
  assign out_mismatch = w_mismatch;
  assign busy         = w_busy;
  assign done         = w_done;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_mult_table_scanner.sv
// Bench for mult_table_scanner: two instances (check enabled / disabled) each
// driving its own registered times-table memory model, compared every cycle
// against a beat-level model of the scan.
module tb_mult_table_scanner;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start;
  logic       out_ready;

  logic [2:0] mul_a, mul_b, out_a, out_b;
  logic       mul_read, out_valid, out_mismatch, busy, done;
  logic [5:0] mul_result, out_result;
  logic [6:0] err_count;

  logic [2:0] mul_a_0, mul_b_0, out_a_0, out_b_0;
  logic       mul_read_0, out_valid_0, out_mismatch_0, busy_0, done_0;
  logic [5:0] mul_result_0, out_result_0;
  logic [6:0] err_count_0;

  mult_table_scanner #(.CHECK_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_read(mul_read), .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_result(out_result), .out_mismatch(out_mismatch),
    .busy(busy), .done(done), .err_count(err_count)
  );

  mult_table_scanner #(.CHECK_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mul_a(mul_a_0), .mul_b(mul_b_0), .mul_read(mul_read_0), .mul_result(mul_result_0),
    .out_valid(out_valid_0), .out_ready(out_ready), .out_a(out_a_0), .out_b(out_b_0),
    .out_result(out_result_0), .out_mismatch(out_mismatch_0),
    .busy(busy_0), .done(done_0), .err_count(err_count_0)
  );

  // Memory contents shared by both memory models; changed only between scans.
  logic [5:0] mem [64];
  logic [5:0] r_mq, r_mq0;

  // Registered read port: data appears the cycle after a read and holds otherwise.
  always @(posedge clk) begin
    if (mul_read) r_mq <= mem[{mul_a, mul_b}];
    if (mul_read_0) r_mq0 <= mem[{mul_a_0, mul_b_0}];
  end
  assign mul_result   = r_mq;
  assign mul_result_0 = r_mq0;

  int n_checks = 0;
  int n_errors = 0;

  // Beat-level model: beats consumed so far in this scan and mismatches seen.
  bit scan_on   = 1'b0;
  int exp_beat  = 0;
  int model_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin : cmp
    int issued;
    int ex_a, ex_b;
    bit ex_mm;
    check("cmp_err0", err_count_0, 0);
    check("cmp_mm0", out_mismatch_0, 0);
    if (!rst_n || !scan_on) begin
      check("idle_valid", out_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_read", mul_read, 0);
      check("idle_err", err_count, 0);
    end else begin
      check("cmp_busy", busy, (exp_beat < 64) ? 1 : 0);
      check("cmp_done", done, (exp_beat == 64) ? 1 : 0);
      check("cmp_err", err_count, model_err);
      issued = exp_beat + (out_valid ? 1 : 0);
      check("cmp_read", mul_read,
            ((exp_beat < 64) && (issued < 64) && (!out_valid || out_ready)) ? 1 : 0);
      if (mul_read) begin
        check("cmp_mul_a", mul_a, issued / 8);
        check("cmp_mul_b", mul_b, issued % 8);
      end
      if (out_valid && exp_beat >= 64) begin
        check("extra_beat", out_valid, 0);
      end else if (out_valid) begin
        ex_a  = exp_beat / 8;
        ex_b  = exp_beat % 8;
        ex_mm = (int'(mem[exp_beat]) != ex_a * ex_b);
        check("cmp_out_a", out_a, ex_a);
        check("cmp_out_b", out_b, ex_b);
        check("cmp_result", out_result, mem[exp_beat]);
        check("cmp_mismatch", out_mismatch, ex_mm);
        if (out_ready) begin
          exp_beat++;
          model_err += ex_mm ? 1 : 0;
        end
      end else begin
        check("cmp_mm_idle", out_mismatch, 0);
      end
    end
  end

  task automatic start_scan();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    scan_on   = 1'b1;
    exp_beat  = 0;
    model_err = 0;
  endtask

  task automatic wait_pair(input int a, input int b, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (out_valid && out_a == 3'(a) && out_b == 3'(b)) begin
        found = 1'b1;
        break;
      end
    end
    check("wait_pair", found, 1);
  endtask

  task automatic wait_done(input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("wait_done", found, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit fin;
    for (int i = 0; i < 64; i++) mem[i] = 6'((i / 8) * (i % 8));
    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_err", err_count, 0);
    check("rst_read", mul_read, 0);

    // Full scan without stalls: last beat after E64, DONE at E65.
    start_scan();
    check("e0_read", mul_read, 1);
    check("e0_a", mul_a, 0);
    check("e0_b", mul_b, 0);
    repeat (64) @(posedge clk);
    #1;
    check("e64_valid", out_valid, 1);
    check("e64_a", out_a, 7);
    check("e64_b", out_b, 7);
    check("e64_result", out_result, 49);
    check("e64_done", done, 0);
    @(posedge clk); #1;
    check("e65_done", done, 1);
    check("e65_err", err_count, 0);

    // Backpressure on beat (2,5).
    start_scan();
    wait_pair(2, 5, 100);
    out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_result", out_result, 10);
      check("stall_a", out_a, 2);
      check("stall_b", out_b, 5);
      check("stall_read", mul_read, 0);
      check("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("resume_a", out_a, 2);
    check("resume_b", out_b, 6);
    wait_done(200);
    check("stall_err", err_count, 0);

    // Faulty memory word at (3,3).
    mem[27] = 6'd13;
    start_scan();
    wait_pair(3, 3, 100);
    check("fault_result", out_result, 13);
    check("fault_mm", out_mismatch, 1);
    check("fault_mm_dis", out_mismatch_0, 0);
    wait_done(200);
    check("fault_err", err_count, 1);
    check("fault_err_dis", err_count_0, 0);

    // Restart from DONE clears the tally; random ready with a start pulse mid-scan.
    mem[27] = 6'd9;
    start_scan();
    check("restart_err", err_count, 0);
    check("restart_read", mul_read, 1);
    check("restart_a", mul_a, 0);
    check("restart_b", mul_b, 0);
    fin = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      start = (c == 30) ? 1'b1 : 1'b0;
      if (done) begin
        fin = 1'b1;
        break;
      end
      out_ready = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("random_done", fin, 1);
    check("random_beats", exp_beat, 64);

    // Reset in the middle of a scan.
    start_scan();
    wait_pair(2, 4, 100);
    #2 rst_n = 1'b0;
    scan_on   = 1'b0;
    exp_beat  = 0;
    model_err = 0;
    #1;
    check("rstmid_valid", out_valid, 0);
    check("rstmid_read", mul_read, 0);
    check("rstmid_busy", busy, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);
    start_scan();
    wait_done(200);
    check("post_rst_err", err_count, 0);
    check("post_rst_beats", exp_beat, 64);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_table_scanner.md
# mult_table_scanner

Sequencer and checker that sits directly upstream of the memory-based times-table `multiplier`. On `start` it walks every operand pair (a,b) = (0,0)…(7,7) in row-major order, drives the multiplier's `a`, `b` and `read` inputs, and aligns the returned product with the operands that produced it. Each result is emitted on a valid/ready output stream, checked against an arithmetic `a*b`, and counted into an error tally for board-level self-test of the memory contents.

## Interface
Parameters:
- `CHECK_EN`, default 1. 1 enables the mismatch check; 0 forces `out_mismatch` = 0 and freezes `err_count` at 0.

Ports:
- `clk`  in  1  Sole clock; all state changes on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `start`  in  1  Begin a scan. Sampled only in IDLE or DONE.
- `mul_a`  out  3  Operand a to `multiplier`.
- `mul_b`  out  3  Operand b to `multiplier`.
- `mul_read`  out  1  Read enable to `multiplier`.
- `mul_result`  in  6  Product from `multiplier`. Valid the cycle after a read; held while `mul_read` = 0.
- `out_valid`  out  1  Output beat present.
- `out_ready`  in  1  Downstream accepts the beat.
- `out_a`, `out_b`  out  3 each  Operands of the current beat.
- `out_result`  out  6  Equals `mul_result`.
- `out_mismatch`  out  1  `out_result` ≠ `out_a*out_b` (6-bit unsigned compare), qualified by `out_valid`.
- `busy`  out  1  High in SCAN or DRAIN.
- `done`  out  1  High in DONE.
- `err_count`  out  7  Mismatches in the current or last scan, range 0..64.

## Operation
- **Index.** 6-bit index `idx`. `mul_a` = `idx[5:3]` and `mul_b` = `idx[2:0]`, matching the multiplier's address `a*8+b`.
- **Read issue.** Combinational: `mul_read` = (state==SCAN) && (!out_valid || out_ready). A read never overwrites an unconsumed beat.
- **Read accepted** (`mul_read` high at an edge):
  - `out_a`/`out_b` ← `mul_a`/`mul_b`.
  - `out_valid` ← 1.
  - `idx` ← `idx`+1.
- **Beat consumed without a new read.** `out_valid` ← 0.
- **Error count.** `err_count` increments on each consumed beat (`out_valid && out_ready`) where `out_mismatch` = 1. Saturation is not needed because the maximum is 64.
- **States:**
  - IDLE: outputs quiet. `start` → SCAN, with `idx` ← 0 and `err_count` ← 0.
  - SCAN: issue reads. A read accepted with `idx` = 63 → DRAIN (`idx` wraps to 0 and is unused).
  - DRAIN: no reads. Consumption of the final beat → DONE.
  - DONE: `done` = 1; `err_count` holds. `start` → SCAN with the same clears as from IDLE.
- **`start` elsewhere.** Ignored in SCAN and DRAIN.
- **Reset values** (`rst_n` low, immediately and asynchronously): state = IDLE; `idx`, `out_a`, `out_b`, `err_count` = 0; `out_valid`, `busy`, `done` = 0. `mul_read` is therefore 0 at once.
- **Reset mid-scan.** Abandons the scan. No beat is emitted after reset is released until a new `start`.

## Timing
- **Start.** `start` is sampled at edge E0 and the state becomes SCAN. `mul_read` = 1 in the cycle after E0, with `mul_a`=0 and `mul_b`=0.
- **First beat.** `out_valid` is high after edge E1, with `out_result` = `mul_result` for (0,0).
- **Throughput.** With `out_ready` held at 1, one beat per cycle. The beat for (7,7) appears after E64, and DONE is reached at E65.
- **Latency.** One cycle from read to beat. No output register beyond the memory's own register; `out_result` is a wire from `mul_result`.
- **Backpressure.** With `out_valid` && !`out_ready`: `mul_read` = 0 and `out_a`, `out_b`, `out_result` hold, since the memory holds `douta` while `ena` = 0. Resumption is seamless and no pair is skipped or repeated.
- **Simultaneous events.** Consume and issue in the same cycle keeps `out_valid` = 1 and loads the new operands.

## Test plan
- **Full scan, no stall.** Drive `start` pulse with `out_ready`=1 and a correct memory model → 64 consecutive beats; beat n carries a=n/8, b=n%8, result=a*b; `done` high at E65; `err_count`=0.
- **Backpressure.** Hold `out_ready`=0 for 3 cycles while beat (2,5) is presented → `out_result`=10 held steady, `mul_read`=0 during the stall, next beat is (2,6), and the total is still 64 beats.
- **Fault detection.** Memory model returns 13 for (3,3) → that beat has `out_mismatch`=1 and final `err_count`=1. Repeat with `CHECK_EN`=0 → `err_count`=0.
- **Ignored and restart.** Pulse `start` during SCAN → no effect. Pulse `start` in DONE after a faulty run → `err_count` cleared to 0 and a fresh scan starts at (0,0).
- **Reset mid-scan.** Assert `rst_n`=0 at beat 20 → `out_valid`, `mul_read`, `busy` fall immediately; after release, outputs stay idle until `start`.
- **Random ready.** Apply 50% random `out_ready` → exactly 64 beats in order, each a*b correct, and `done` asserted only after the last beat is consumed.
